// File: rtl/io_access_fabric.sv
// Registered I/O access fabric: decodes one CPU access against N_TGT [base, limit) regions,
// selects the matched target, waits for its ready (bounded by TIMEOUT) and returns the response.
module io_access_fabric #(
  parameter int                       ADDR_W        = 7,
  parameter int                       DATA_W        = 8,
  parameter int                       N_TGT         = 8,
  parameter logic [N_TGT*ADDR_W-1:0]  TGT_BASE      = '0,
  parameter logic [N_TGT*ADDR_W-1:0]  TGT_LIMIT     = '0,
  parameter int                       TIMEOUT       = 15,
  parameter logic [DATA_W-1:0]        UNMAPPED_DATA = {DATA_W{1'b1}}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic                      busy,
  output logic                      rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic [N_TGT-1:0]          tgt_sel,
  output logic                      tgt_we,
  output logic [ADDR_W-1:0]         tgt_off,
  output logic [DATA_W-1:0]         tgt_wdata,
  input  logic [N_TGT-1:0]          tgt_ready,
  input  logic [N_TGT*DATA_W-1:0]   tgt_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [N_TGT-1:0]   match;
  logic               hit;
  logic [N_TGT-1:0]   sel_next;
  logic [ADDR_W-1:0]  hit_base;
  logic               sel_ready;
  logic [DATA_W-1:0]  sel_rdata;

  // A disabled region (base >= limit) can never satisfy both compares.
  for (genvar gi = 0; gi < N_TGT; gi++) begin : g_match
    assign match[gi] = (addr >= TGT_BASE[gi*ADDR_W +: ADDR_W]) &&
                       (addr <  TGT_LIMIT[gi*ADDR_W +: ADDR_W]);
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    sel_next = '0;
    hit_base = '0;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit      = 1'b1;
        sel_next = N_TGT'(1) << i;
        hit_base = TGT_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    sel_ready = |(tgt_ready & tgt_sel);
    sel_rdata = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (tgt_sel[i]) sel_rdata = sel_rdata | tgt_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      tgt_sel   <= '0;
      tgt_we    <= 1'b0;
      tgt_off   <= '0;
      tgt_wdata <= '0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            busy    <= 1'b1;
            cnt_reg <= '0;
            if (hit) begin
              tgt_sel   <= sel_next;
              tgt_we    <= we;
              tgt_off   <= addr - hit_base;
              tgt_wdata <= wdata;
              state_reg <= ACCESS;
            end else begin
              rvalid    <= 1'b1;
              err       <= 1'b1;
              rdata     <= UNMAPPED_DATA;
              state_reg <= RESP;
            end
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          // Ready is checked first so it wins on the timeout cycle.
          if (sel_ready) begin
            rvalid    <= 1'b1;
            rdata     <= tgt_we ? '0 : sel_rdata;
            tgt_sel   <= '0;
            tgt_we    <= 1'b0;
            state_reg <= RESP;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            rvalid    <= 1'b1;
            err       <= 1'b1;
            rdata     <= UNMAPPED_DATA;
            tgt_sel   <= '0;
            tgt_we    <= 1'b0;
            state_reg <= RESP;
          end
        end
        RESP: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          tgt_sel   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_access_fabric.sv
// Scoreboard bench for io_access_fabric: a base-map instance (7-bit) and an overlap-map
// instance (8-bit, short timeout), driven one at a time with directed and random accesses.
module tb_io_access_fabric;

  localparam logic [55:0] BASE_A = {7'h00, 7'h00, 7'h00, 7'h68, 7'h40, 7'h10, 7'h04, 7'h00};
  localparam logic [55:0] LIM_A  = {7'h00, 7'h00, 7'h00, 7'h6D, 7'h4C, 7'h40, 7'h08, 7'h01};
  localparam logic [63:0] BASE_B = {8'h00, 8'h00, 8'h00, 8'h68, 8'h40, 8'h10, 8'h04, 8'h00};
  localparam logic [63:0] LIM_B  = {8'h00, 8'h00, 8'h80, 8'h6D, 8'h4C, 8'h40, 8'h08, 8'h01};

  int base_m [2][8] = '{'{0, 4, 16, 64, 104, 0, 0, 0}, '{0, 4, 16, 64, 104, 0, 0, 0}};
  int lim_m  [2][8] = '{'{1, 8, 64, 76, 109, 0, 0, 0}, '{1, 8, 64, 76, 109, 128, 0, 0}};
  int tmo_m  [2]    = '{15, 3};
  logic [7:0] unm_m [2] = '{8'hFF, 8'hA5};

  logic clk = 1'b0;
  logic reset;
  logic req_a, req_b, we;
  logic [7:0] addr, wdata;
  logic [7:0] tgt_ready;
  logic [63:0] tgt_rdata;

  logic busy_a, rvalid_a, err_a, tgt_we_a;
  logic [7:0] rdata_a, tgt_sel_a, tgt_wdata_a;
  logic [6:0] tgt_off_a;
  logic busy_b, rvalid_b, err_b, tgt_we_b;
  logic [7:0] rdata_b, tgt_sel_b, tgt_wdata_b, tgt_off_b;

  io_access_fabric #(.ADDR_W(7), .DATA_W(8), .N_TGT(8), .TGT_BASE(BASE_A), .TGT_LIMIT(LIM_A),
                     .TIMEOUT(15), .UNMAPPED_DATA(8'hFF)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr[6:0]), .wdata(wdata),
    .busy(busy_a), .rvalid(rvalid_a), .rdata(rdata_a), .err(err_a), .tgt_sel(tgt_sel_a),
    .tgt_we(tgt_we_a), .tgt_off(tgt_off_a), .tgt_wdata(tgt_wdata_a),
    .tgt_ready(tgt_ready), .tgt_rdata(tgt_rdata));

  io_access_fabric #(.ADDR_W(8), .DATA_W(8), .N_TGT(8), .TGT_BASE(BASE_B), .TGT_LIMIT(LIM_B),
                     .TIMEOUT(3), .UNMAPPED_DATA(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_b), .rvalid(rvalid_b), .rdata(rdata_b), .err(err_b), .tgt_sel(tgt_sel_b),
    .tgt_we(tgt_we_b), .tgt_off(tgt_off_b), .tgt_wdata(tgt_wdata_b),
    .tgt_ready(tgt_ready), .tgt_rdata(tgt_rdata));

  always #5 clk = ~clk;

  bit act = 1'b0;
  logic m_busy, m_rvalid, m_err, m_tgt_we;
  logic [7:0] m_rdata, m_sel, m_off, m_wdata;
  assign m_busy   = act ? busy_b      : busy_a;
  assign m_rvalid = act ? rvalid_b    : rvalid_a;
  assign m_err    = act ? err_b       : err_a;
  assign m_tgt_we = act ? tgt_we_b    : tgt_we_a;
  assign m_rdata  = act ? rdata_b     : rdata_a;
  assign m_sel    = act ? tgt_sel_b   : tgt_sel_a;
  assign m_off    = act ? tgt_off_b   : {1'b0, tgt_off_a};
  assign m_wdata  = act ? tgt_wdata_b : tgt_wdata_a;

  typedef struct {
    int k; bit we; logic [7:0] wdata; logic [7:0] off; logic [7:0] rdata;
    bit err; int lat; int selc; int issue;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cur_delay = 0;
  int acc_cyc = 0;
  int sel_cnt = 0;
  exp_t me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int decode(input int d, input int a);
    for (int i = 0; i < 8; i++)
      if (base_m[d][i] < lim_m[d][i] && a >= base_m[d][i] && a < lim_m[d][i]) return i;
    return -1;
  endfunction

  // Target side: the selected target raises ready after cur_delay cycles; other bits are noise.
  always @(negedge clk) begin
    logic [7:0] rdy;
    if (m_sel != 0) acc_cyc = acc_cyc + 1;
    else acc_cyc = 0;
    rdy = 8'($urandom);
    for (int j = 0; j < 8; j++)
      if (m_sel[j]) rdy[j] = (acc_cyc >= cur_delay + 1);
    tgt_ready = rdy;
  end

  // Monitor: checks held target-side outputs each ACCESS cycle, pops on rvalid.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_sel != 0) begin
        if (q.size() == 0) chk("sel_without_access", {24'd0, m_sel}, 32'd0);
        else begin
          me = q[0];
          chk("tgt_sel", {24'd0, m_sel}, 32'd1 << me.k);
          chk("tgt_off", {24'd0, m_off}, {24'd0, me.off});
          chk("tgt_we", {31'd0, m_tgt_we}, {31'd0, me.we});
          if (me.we) chk("tgt_wdata", {24'd0, m_wdata}, {24'd0, me.wdata});
          sel_cnt++;
        end
      end
      if (m_rvalid) begin
        if (q.size() == 0) chk("spurious_rvalid", 32'd1, 32'd0);
        else begin
          me = q.pop_front();
          $display("txn dut=%0d k=%0d we=%0d rdata=%0h err=%0d lat=%0d", act, me.k, me.we,
                   m_rdata, m_err, cyc - me.issue);
          chk("rdata", {24'd0, m_rdata}, {24'd0, me.rdata});
          chk("err", {31'd0, m_err}, {31'd0, me.err});
          chk("latency", cyc - me.issue, me.lat);
          chk("sel_cycles", sel_cnt, me.selc);
          chk("sel_in_resp", {24'd0, m_sel}, 32'd0);
        end
      end
      if (!m_busy) sel_cnt = 0;
    end
  end

  task automatic txn(input bit w, input int a, input int wd, input int d, input int force_rd);
    exp_t e;
    int k, g;
    g = 0;
    while (m_busy && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("busy_stuck", 32'd1, 32'd0);
    tgt_rdata = {$urandom, $urandom};
    cur_delay = d;
    k = decode(act, a);
    if (k >= 0 && force_rd >= 0) tgt_rdata[k*8 +: 8] = force_rd[7:0];
    e.k = k; e.we = w; e.wdata = wd[7:0]; e.issue = cyc;
    e.off = (k >= 0) ? 8'(a - base_m[act][k]) : 8'd0;
    if (k < 0) begin
      e.rdata = unm_m[act]; e.err = 1'b1; e.lat = 1; e.selc = 0;
    end else if (d < tmo_m[act]) begin
      e.rdata = w ? 8'd0 : tgt_rdata[k*8 +: 8]; e.err = 1'b0; e.lat = d + 2; e.selc = d + 1;
    end else begin
      e.rdata = unm_m[act]; e.err = 1'b1; e.lat = tmo_m[act] + 1; e.selc = tmo_m[act];
    end
    q.push_back(e);
    we = w; addr = a[7:0]; wdata = wd[7:0];
    if (act) req_b = 1'b1; else req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    g = 0;
    while (q.size() != 0 && g < 100) begin @(negedge clk); g++; end
    if (q.size() != 0) begin
      chk("rvalid_wait_expired", 32'd1, 32'd0);
      q.delete();
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tgt_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs_a", {12'd0, busy_a, rvalid_a, err_a, tgt_we_a, tgt_sel_a, rdata_a}, 32'd0);
    chk("rst_data_a", {17'd0, tgt_off_a, tgt_wdata_a}, 32'd0);
    chk("rst_outs_b", {12'd0, busy_b, rvalid_b, err_b, tgt_we_b, tgt_sel_b, rdata_b}, 32'd0);
    chk("rst_data_b", {16'd0, tgt_off_b, tgt_wdata_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    act = 1'b0;
    txn(0, 'h05, 0, 0, 'h3C);
    txn(1, 'h6A, 'h77, 3, -1);
    txn(0, 'h4D, 0, 0, -1);
    txn(0, 'h20, 0, 1000, -1);
    txn(0, 'h30, 0, 14, -1);
    txn(0, 'h30, 0, 15, -1);
    foreach (base_m[0][i]) if (i < 5) begin
      txn(0, base_m[0][i], 0, 0, -1);
      txn(1, lim_m[0][i] - 1, 'h5A, 1, -1);
      txn(0, lim_m[0][i], 0, 0, -1);
    end
    txn(1, 'h7F, 'h12, 0, -1);
    for (int n = 0; n < 60; n++)
      txn(1'($urandom), $urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 17), -1);

    // Reset during ACCESS cycle 2 of a stalled read: no rvalid, fabric returns to idle.
    cur_delay = 1000;
    e.k = 2; e.we = 1'b0; e.wdata = 8'd0; e.off = 8'h10; e.rdata = 8'd0; e.err = 1'b0;
    e.lat = 0; e.selc = 0; e.issue = cyc;
    q.push_back(e);
    we = 1'b0; addr = 8'h20; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_sel", {24'd0, tgt_sel_a}, 32'd0);
    chk("abort_rvalid", {31'd0, rvalid_a}, 32'd0);
    q.delete();
    reset = 1'b0;
    @(negedge clk);
    txn(0, 'h00, 0, 0, -1);

    act = 1'b1;
    txn(0, 'h05, 0, 0, -1);
    txn(0, 'h7F, 0, 0, 'h9E);
    txn(0, 'h4D, 0, 1, -1);
    txn(0, 'h80, 0, 0, -1);
    txn(0, 'h20, 0, 2, -1);
    txn(0, 'h20, 0, 3, -1);
    txn(1, 'h45, 'hC3, 1, -1);
    for (int n = 0; n < 40; n++)
      txn(1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 5), -1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
